fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 106 ++++++++++
 tb/tb_fifo_reader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Burst reader: pops burst_len words from a first-word fall-through FIFO and
// presents them downstream through a 2-entry skid buffer with valid/ready.
module fifo_reader #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] data_out,
    output logic             r_ready,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] fetch_left, fetch_nxt;
    logic [LEN_W-1:0] sent_left, sent_nxt;
    logic [WIDTH-1:0] skid [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic             pop, xfer, done_nxt;

    assign m_valid = (count != 2'd0);
    assign m_data  = skid[rd_ptr];
    assign m_last  = m_valid && (sent_left == LEN_W'(1));
    assign xfer    = m_valid && m_ready;
    assign busy    = (state != IDLE);

    // A full buffer may still accept a word when the head leaves on the same edge.
    assign r_ready = (state == RUN) && !fifo_empty && (fetch_left != '0) &&
                     ((count < 2'd2) || xfer);
    assign pop     = r_ready;

    always_comb begin
        state_nxt = state;
        fetch_nxt = fetch_left;
        sent_nxt  = sent_left;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        fetch_nxt = burst_len;
                        sent_nxt  = burst_len;
                        state_nxt = RUN;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (pop) begin
                    fetch_nxt = fetch_left - LEN_W'(1);
                    if (fetch_left == LEN_W'(1)) state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (xfer && (sent_left == LEN_W'(1))) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (xfer) sent_nxt = sent_left - LEN_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_left <= '0;
            sent_left  <= '0;
            done       <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            skid[0]    <= '0;
            skid[1]    <= '0;
        end else begin
            state      <= state_nxt;
            fetch_left <= fetch_nxt;
            sent_left  <= sent_nxt;
            done       <= done_nxt;
            if (pop) begin
                skid[wr_ptr] <= data_out;
                wr_ptr       <= ~wr_ptr;
            end
            if (xfer) rd_ptr <= ~rd_ptr;
            case ({pop, xfer})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: queue-based FIFO source, transaction-level model of the
// burst/buffer behaviour checked every cycle, directed scenarios plus random bursts.
module tb_fifo_reader;

    localparam int WIDTH = 32;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] burst_len = '0;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] data_out = '0;
    logic             m_ready = 1'b0;
    logic             r_ready, m_valid, m_last, busy, done;
    logic [WIDTH-1:0] m_data;

    always #5 clk = ~clk;

    fifo_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .data_out(data_out), .r_ready(r_ready),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    int checks = 0;
    int passed = 0;

    logic [WIDTH-1:0] src_q[$];
    logic [WIDTH-1:0] exp_buf[$];
    bit               active = 0;
    int               len = 0, pops = 0, sent = 0;
    bit               done_exp = 0;
    int               cyc = 0;

    logic [WIDTH-1:0] xlog[$];
    bit               llog[$];
    int               xcyc[$];
    int               pop_total, rr_cnt, done_cnt, done_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic drive_fifo();
        fifo_empty = (src_q.size() == 0);
        data_out   = fifo_empty ? '0 : src_q[0];
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        src_q.push_back(w);
        drive_fifo();
    endtask

    task automatic clear_logs();
        xlog.delete(); llog.delete(); xcyc.delete();
        pop_total = 0; rr_cnt = 0; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic step();
        bit exp_rr, exp_xfer, dut_pop, take;
        logic [WIDTH-1:0] head;
        #1;
        exp_rr = active && (src_q.size() > 0) && (pops < len) && ((exp_buf.size() < 2) || m_ready);
        chk("r_ready", r_ready, exp_rr);
        chk("m_valid", m_valid, exp_buf.size() > 0);
        chk("busy", busy, active);
        chk("done", done, done_exp);
        if (exp_buf.size() > 0) begin
            chk("m_data", m_data, exp_buf[0]);
            chk("m_last", m_last, (len - sent) == 1);
        end else begin
            chk("m_last_idle", m_last, 0);
        end
        exp_xfer = (exp_buf.size() > 0) && m_ready;
        dut_pop  = r_ready && !fifo_empty;
        take     = start && !active;
        head     = data_out;
        if (r_ready === 1'b1) rr_cnt++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (m_valid === 1'b1 && m_ready) begin
            xlog.push_back(m_data); llog.push_back(m_last); xcyc.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        done_exp = 0;
        if (exp_xfer) begin
            void'(exp_buf.pop_front());
            sent++;
            if (sent == len) begin active = 0; done_exp = 1; end
        end
        if (exp_rr) begin exp_buf.push_back(head); pops++; end
        if (dut_pop) begin void'(src_q.pop_front()); pop_total++; end
        if (take) begin
            if (burst_len != '0) begin
                active = 1; len = int'(burst_len); pops = 0; sent = 0;
            end else begin
                done_exp = 1;
            end
        end
        drive_fifo();
    endtask

    task automatic rnd_inputs();
        if ($urandom_range(0, 1) == 1 && src_q.size() < 6) push($urandom);
        m_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic run_until(input int budget, input bit rnd);
        int n = 0;
        while (active && n < budget) begin
            if (rnd) rnd_inputs();
            step();
            n++;
        end
        chk("burst_timeout", active, 0);
        if (rnd) rnd_inputs();
        step();
    endtask

    task automatic begin_burst(input int l);
        start = 1'b1;
        burst_len = LEN_W'(l);
        step();
        start = 1'b0;
    endtask

    initial begin
        int l;
        drive_fifo();
        clear_logs();
        #12;
        @(negedge clk);
        reset = 1'b1;

        // Basic burst 0,1,2
        push(0); push(1); push(2);
        m_ready = 1'b1;
        begin_burst(3);
        run_until(50, 0);
        chk("basic_rr_cycles", rr_cnt, 3);
        chk("basic_words", xlog.size(), 3);
        for (int i = 0; i < 3 && i < xlog.size(); i++) begin
            chk("basic_data", xlog[i], i);
            chk("basic_last", llog[i], i == 2);
        end
        if (xcyc.size() == 3) begin
            chk("basic_consec", xcyc[2] - xcyc[0], 2);
            chk("basic_done_time", done_cyc, xcyc[2] + 1);
        end
        chk("basic_done_cnt", done_cnt, 1);

        // Backpressure
        clear_logs();
        for (int i = 0; i < 4; i++) push(10 + i);
        m_ready = 1'b0;
        begin_burst(4);
        repeat (5) step();
        chk("bp_pops", pop_total, 2);
        chk("bp_rready", r_ready, 0);
        chk("bp_hold", m_data, 10);
        m_ready = 1'b1;
        run_until(50, 0);
        chk("bp_words", xlog.size(), 4);
        for (int i = 0; i < 4 && i < xlog.size(); i++) chk("bp_data", xlog[i], 10 + i);

        // Empty stall
        clear_logs();
        push(20);
        begin_burst(3);
        repeat (10) step();
        chk("stall_pops", pop_total, 1);
        push(21); push(22);
        run_until(50, 0);
        chk("stall_words", xlog.size(), 3);
        for (int i = 0; i < 3 && i < xlog.size(); i++) chk("stall_data", xlog[i], 20 + i);
        chk("stall_done_cnt", done_cnt, 1);
        if (xcyc.size() == 3) chk("stall_done_time", done_cyc, xcyc[2] + 1);

        // Zero length
        clear_logs();
        push(30);
        begin_burst(0);
        step();
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_rr", rr_cnt, 0);
        chk("zero_pops", pop_total, 0);
        src_q.delete();
        drive_fifo();

        // Start while busy is ignored
        clear_logs();
        push(40); push(41); push(42);
        m_ready = 1'b0;
        begin_burst(3);
        start = 1'b1; burst_len = 8'd7;
        step(); step();
        start = 1'b0;
        m_ready = 1'b1;
        run_until(50, 0);
        chk("busy_start_words", xlog.size(), 3);
        chk("busy_start_pops", pop_total, 3);
        chk("busy_start_done", done_cnt, 1);

        // Reset mid-burst
        clear_logs();
        for (int i = 0; i < 5; i++) push(50 + i);
        m_ready = 1'b0;
        begin_burst(5);
        step(); step();
        #2 reset = 1'b0;
        #1;
        chk("rst_r_ready", r_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        active = 0; exp_buf.delete(); done_exp = 0;
        src_q.delete(); drive_fifo();
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
        push(60); push(61);
        m_ready = 1'b1;
        begin_burst(2);
        run_until(50, 0);
        chk("post_rst_words", xlog.size(), 2);
        for (int i = 0; i < 2 && i < xlog.size(); i++) chk("post_rst_data", xlog[i], 60 + i);

        // Random bursts
        for (int b = 0; b < 200; b++) begin
            if (b == 0) l = 255;
            else if ($urandom_range(0, 7) == 0) l = $urandom_range(17, 255);
            else l = $urandom_range(1, 16);
            clear_logs();
            rnd_inputs();
            begin_burst(l);
            run_until(l * 30 + 100, 1);
            chk("rnd_words", xlog.size(), l);
            chk("rnd_pops", pop_total, l);
            if (llog.size() > 0) chk("rnd_last", llog[llog.size() - 1], 1);
            chk("rnd_done", done_cnt, 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
